// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: bit timing, FSM states, frame layout.
// Used by both the receiver and the transmitter.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    // start + parity + stop around the data bits
    localparam int FRAME_OVERHEAD = 3;

    function automatic int clks_per_bit(int clk_freq, int baud);
        return clk_freq / baud;
    endfunction

    function automatic int frame_bits(int data_width);
        return data_width + FRAME_OVERHEAD;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, parallel word and status out.
// master = the receiver, slave = the consumer/pad side.
interface uart_rx_if #(
    parameter int VLD_DATA_WIDTH = 8
);
    logic                      RX;
    logic [VLD_DATA_WIDTH-1:0] dout;
    logic                      dout_vld;
    logic                      parity_err;
    logic                      frame_err;
    logic                      RX_busy;

    modport master (
        input  RX,
        output dout, dout_vld, parity_err, frame_err, RX_busy
    );

    modport slave (
        output RX,
        input  dout, dout_vld, parity_err, frame_err, RX_busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the RX pin plus falling-edge detect.
// All flops clear to 0 so a line held low through reset gives no edge.
module uart_rx_sync (
    input  logic CLK,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);
    logic rx_m;
    logic rx_d;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b0;
            rx_s <= 1'b0;
            rx_d <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, LSB-first data, parity, stop -> parallel word.
// Data is delivered even on parity/frame error; flags qualify it.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD_RATE      = 115200,
    parameter int CLK_FREQ       = 10_000_000,
    parameter int VLD_DATA_WIDTH = 8,
    parameter int CHECK_SEL      = 1
) (
    input logic      CLK,
    input logic      rst,
    uart_rx_if.master bus
);
    localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int IW   = (VLD_DATA_WIDTH > 1) ? $clog2(VLD_DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(VLD_DATA_WIDTH - 1);

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic [VLD_DATA_WIDTH-1:0] shreg;
    logic                      perr_next;
    logic [VLD_DATA_WIDTH-1:0] dout_r;
    logic                      vld_r;
    logic                      perr_r;
    logic                      ferr_r;
    logic                      rx_s;
    logic                      fall;
    logic                      exp_par;

    uart_rx_sync u_sync (
        .CLK  (CLK),
        .rst  (rst),
        .rx   (bus.RX),
        .rx_s (rx_s),
        .fall (fall)
    );

    assign exp_par = (CHECK_SEL != 0) ? ~^shreg : ^shreg;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            perr_next <= 1'b0;
            dout_r    <= '0;
            vld_r     <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            vld_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fall) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        // line back high at mid-start: treat as glitch
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= VLD_DATA_WIDTH'({rx_s, shreg} >> 1);
                        if (idx == IDX_LAST) begin
                            state <= PARITY;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        perr_next <= (rx_s != exp_par);
                        state     <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        dout_r <= shreg;
                        perr_r <= perr_next;
                        ferr_r <= ~rx_s;
                        vld_r  <= 1'b1;
                        state  <= rx_s ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_vld   = vld_r;
    assign bus.parity_err = perr_r;
    assign bus.frame_err  = ferr_r;
    assign bus.RX_busy    = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames
// checked against a frame-level reference model.
module tb_uart_rx;
    localparam int CPB  = 10_000_000 / 115200;
    localparam int HALF = CPB / 2;
    // line fall -> D is 2 clocks; dout_vld one clock after the stop sample
    localparam int LAT  = 2 + HALF + (8 + 2) * CPB + 1;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    uart_rx_if #(.VLD_DATA_WIDTH(8)) bus ();

    uart_rx #(
        .BAUD_RATE      (115200),
        .CLK_FREQ       (10_000_000),
        .VLD_DATA_WIDTH (8),
        .CHECK_SEL      (1)
    ) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    int         q_cyc[$];
    logic [7:0] q_d[$];
    logic       q_pe[$];
    logic       q_fe[$];

    always @(negedge CLK) begin
        if (bus.dout_vld === 1'b1) begin
            q_cyc.push_back(cyc);
            q_d.push_back(bus.dout);
            q_pe.push_back(bus.parity_err);
            q_fe.push_back(bus.frame_err);
        end
    end

    // odd parity: ones in data plus parity bit must be odd
    function automatic logic model_perr(logic [7:0] d, logic p);
        return ((($countones(d) + int'(p)) % 2) == 0);
    endfunction

    function automatic logic good_par(logic [7:0] d);
        return (($countones(d) % 2) == 0);
    endfunction

    task automatic clear_q();
        q_cyc.delete();
        q_d.delete();
        q_pe.delete();
        q_fe.delete();
    endtask

    task automatic sync_edge();
        @(posedge CLK);
        #1;
    endtask

    // caller is just after a posedge; n = that edge's index
    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s, output int n);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        n = cyc;
        for (int i = 0; i < 11; i++) begin
            bus.RX = bits[i];
            repeat (CPB) @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.RX = 1'b1;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (bus.dout !== 8'h00) begin
            bad++; $display("FAIL reset_dout got %h want 00", bus.dout);
        end
        total++;
        if (bus.dout_vld !== 1'b0) begin
            bad++; $display("FAIL reset_vld got %b want 0", bus.dout_vld);
        end
        total++;
        if (bus.parity_err !== 1'b0) begin
            bad++; $display("FAIL reset_perr got %b want 0", bus.parity_err);
        end
        total++;
        if (bus.frame_err !== 1'b0) begin
            bad++; $display("FAIL reset_ferr got %b want 0", bus.frame_err);
        end
        total++;
        if (bus.RX_busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got %b want 0", bus.RX_busy);
        end
        sync_edge();
        rst = 1'b0;
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (bus.RX_busy !== 1'b0) begin
            bad++; $display("FAIL post_reset_busy got %b want 0", bus.RX_busy);
        end
    endtask

    task automatic test_basic();
        int n;
        clear_q();
        sync_edge();
        send_frame(8'hA5, 1'b1, 1'b1, n);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (q_cyc.size() !== 1) begin
            bad++; $display("FAIL basic_count got %0d want 1", q_cyc.size());
        end
        if (q_cyc.size() >= 1) begin
            total++;
            if (q_cyc[0] !== n + LAT) begin
                bad++;
                $display("FAIL basic_time got %0d want %0d", q_cyc[0], n + LAT);
            end
            total++;
            if (q_d[0] !== 8'hA5) begin
                bad++; $display("FAIL basic_dout got %h want a5", q_d[0]);
            end
            total++;
            if (q_pe[0] !== model_perr(8'hA5, 1'b1) || q_fe[0] !== 1'b0) begin
                bad++;
                $display("FAIL basic_flags got pe=%b fe=%b want pe=%b fe=0",
                         q_pe[0], q_fe[0], model_perr(8'hA5, 1'b1));
            end
        end
        total++;
        if (bus.dout !== 8'hA5 || bus.RX_busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold got dout=%h busy=%b want a5 0",
                     bus.dout, bus.RX_busy);
        end
    endtask

    task automatic test_parity();
        int n;
        logic [7:0] dv[2];
        dv[0] = 8'h01;
        dv[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            clear_q();
            sync_edge();
            send_frame(dv[k], 1'b1, 1'b1, n);
            repeat (5) @(posedge CLK);
            @(negedge CLK);
            total++;
            if (q_cyc.size() !== 1) begin
                bad++; $display("FAIL parity_count got %0d want 1", q_cyc.size());
            end else begin
                total++;
                if (q_d[0] !== dv[k] || q_pe[0] !== model_perr(dv[k], 1'b1)) begin
                    bad++;
                    $display("FAIL parity_%0d got d=%h pe=%b want d=%h pe=%b", k,
                             q_d[0], q_pe[0], dv[k], model_perr(dv[k], 1'b1));
                end
            end
            total++;
            if (bus.parity_err !== model_perr(dv[k], 1'b1)) begin
                bad++;
                $display("FAIL parity_hold_%0d got %b want %b", k,
                         bus.parity_err, model_perr(dv[k], 1'b1));
            end
        end
    endtask

    task automatic test_frame_err();
        int n;
        clear_q();
        sync_edge();
        send_frame(8'h3C, good_par(8'h3C), 1'b0, n);
        @(negedge CLK);
        total++;
        if (q_cyc.size() !== 1) begin
            bad++; $display("FAIL ferr_count got %0d want 1", q_cyc.size());
        end else begin
            total++;
            if (q_d[0] !== 8'h3C || q_fe[0] !== 1'b1 || q_pe[0] !== 1'b0) begin
                bad++;
                $display("FAIL ferr_frame got d=%h fe=%b pe=%b want 3c 1 0",
                         q_d[0], q_fe[0], q_pe[0]);
            end
        end
        repeat (2 * CPB) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (bus.RX_busy !== 1'b1) begin
            bad++; $display("FAIL ferr_busy_low got %b want 1", bus.RX_busy);
        end
        sync_edge();
        bus.RX = 1'b1;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (bus.RX_busy !== 1'b0) begin
            bad++; $display("FAIL ferr_busy_rise got %b want 0", bus.RX_busy);
        end
        repeat (12 * CPB) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (q_cyc.size() !== 1) begin
            bad++; $display("FAIL ferr_spurious got %0d want 1", q_cyc.size());
        end
    endtask

    task automatic test_false_start();
        int bc;
        bc = 0;
        clear_q();
        sync_edge();
        bus.RX = 1'b0;
        fork
            begin
                repeat (20) @(posedge CLK);
                #1;
                bus.RX = 1'b1;
            end
            begin
                repeat (150) begin
                    @(negedge CLK);
                    if (bus.RX_busy === 1'b1) bc++;
                end
            end
        join
        total++;
        if (bc !== HALF) begin
            bad++; $display("FAIL false_busy_len got %0d want %0d", bc, HALF);
        end
        total++;
        if (q_cyc.size() !== 0) begin
            bad++; $display("FAIL false_vld got %0d want 0", q_cyc.size());
        end
        total++;
        if (bus.dout !== 8'h3C || bus.frame_err !== 1'b1 || bus.parity_err !== 1'b0) begin
            bad++;
            $display("FAIL false_hold got d=%h fe=%b pe=%b want 3c 1 0",
                     bus.dout, bus.frame_err, bus.parity_err);
        end
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        clear_q();
        sync_edge();
        send_frame(8'h55, good_par(8'h55), 1'b1, n1);
        send_frame(8'hAA, good_par(8'hAA), 1'b1, n2);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (q_cyc.size() !== 2) begin
            bad++; $display("FAIL b2b_count got %0d want 2", q_cyc.size());
        end else begin
            total++;
            if (q_cyc[1] - q_cyc[0] !== 11 * CPB || q_cyc[0] !== n1 + LAT) begin
                bad++;
                $display("FAIL b2b_time got %0d,%0d want %0d,%0d",
                         q_cyc[0], q_cyc[1], n1 + LAT, n2 + LAT);
            end
            total++;
            if (q_d[0] !== 8'h55 || q_d[1] !== 8'hAA || q_pe[0] !== 1'b0 ||
                q_pe[1] !== 1'b0 || q_fe[0] !== 1'b0 || q_fe[1] !== 1'b0) begin
                bad++;
                $display("FAIL b2b_data got %h %h pe=%b%b fe=%b%b want 55 aa 00 00",
                         q_d[0], q_d[1], q_pe[0], q_pe[1], q_fe[0], q_fe[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_q();
        sync_edge();
        bus.RX = 1'b0;
        repeat (CPB) @(posedge CLK);
        #1;
        bus.RX = 1'b1;
        repeat (3 * CPB + 20) @(posedge CLK);
        #1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            total++;
            if (bus.dout !== 8'h00 || bus.RX_busy !== 1'b0 || bus.dout_vld !== 1'b0 ||
                bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0) begin
                bad++;
                $display("FAIL midrst_out got d=%h busy=%b vld=%b pe=%b fe=%b want 0",
                         bus.dout, bus.RX_busy, bus.dout_vld,
                         bus.parity_err, bus.frame_err);
            end
        end
        sync_edge();
        rst = 1'b0;
        repeat (12 * CPB) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (q_cyc.size() !== 0) begin
            bad++; $display("FAIL midrst_drop got %0d want 0", q_cyc.size());
        end
        sync_edge();
        send_frame(8'h12, good_par(8'h12), 1'b1, n);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (q_cyc.size() !== 1) begin
            bad++; $display("FAIL midrst_count got %0d want 1", q_cyc.size());
        end else begin
            total++;
            if (q_d[0] !== 8'h12 || q_pe[0] !== 1'b0 || q_fe[0] !== 1'b0 ||
                q_cyc[0] !== n + LAT) begin
                bad++;
                $display("FAIL midrst_frame got d=%h pe=%b fe=%b t=%0d want 12 0 0 %0d",
                         q_d[0], q_pe[0], q_fe[0], q_cyc[0], n + LAT);
            end
        end
    endtask

    task automatic test_random();
        int n;
        logic [7:0] d;
        logic p;
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom);
            p = 1'($urandom);
            clear_q();
            repeat ($urandom_range(0, 40)) @(posedge CLK);
            sync_edge();
            send_frame(d, p, 1'b1, n);
            repeat (3) @(posedge CLK);
            @(negedge CLK);
            total++;
            if (q_cyc.size() !== 1) begin
                bad++; $display("FAIL rand_count_%0d got %0d want 1", k, q_cyc.size());
            end else begin
                total++;
                if (q_d[0] !== d || q_pe[0] !== model_perr(d, p) ||
                    q_fe[0] !== 1'b0 || q_cyc[0] !== n + LAT) begin
                    bad++;
                    $display("FAIL rand_%0d got d=%h pe=%b fe=%b t=%0d want %h %b 0 %0d",
                             k, q_d[0], q_pe[0], q_fe[0], q_cyc[0],
                             d, model_perr(d, p), n + LAT);
                end
            end
        end
    endtask

    initial begin
        bus.RX = 1'b1;
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_false_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
